// File: rtl/shift_operand_pipe.sv
// Two-stage shifter-operand (Val2) unit: S1 decodes the source and folds the
// architectural special cases, S2 runs a log2(WIDTH)-level barrel shifter.
module shift_operand_pipe #(
  parameter int WIDTH         = 32,
  parameter bit OFFSET_SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             imm,
  input  logic             mem_R_en,
  input  logic             mem_W_en,
  input  logic [11:0]      shift_operand,
  input  logic [WIDTH-1:0] val_rm,
  input  logic [7:0]       val_rs,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] val2,
  output logic             carry_out
);

  localparam int LOG = $clog2(WIDTH);

  // K_PASS means S1 already resolved the result; S2 just forwards data/carry.
  typedef enum logic [2:0] {K_PASS, K_LSL, K_LSR, K_ASR, K_ROR} kind_e;

  logic             w_s1_adv;
  logic             w_s2_adv;
  logic [7:0]       w_amt8;
  kind_e            w_kind;
  logic [LOG-1:0]   w_amt;
  logic [WIDTH-1:0] w_data;
  logic             w_c;
  logic             w_msb;

  logic             r_s1_valid;
  kind_e            r_s1_kind;
  logic [LOG-1:0]   r_s1_amt;
  logic [WIDTH-1:0] r_s1_data;
  logic             r_s1_c;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_val2;
  logic             r_carry;

  logic [WIDTH:0]   w_ext;
  logic [WIDTH-1:0] w_rot;
  logic [WIDTH-1:0] w_res;
  logic             w_cres;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  // Decode: every amount-0 / amount>=WIDTH encoding collapses to K_PASS so the
  // barrel only ever sees 0 < n < WIDTH (or any n for ROR).
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_kind = K_PASS;
    w_amt  = '0;
    w_data = val_rm;
    w_c    = carry_in;
    w_msb  = val_rm[WIDTH-1];
    w_amt8 = shift_operand[4] ? val_rs : {3'b000, shift_operand[11:7]};
    if (mem_R_en || mem_W_en) begin
      w_data = OFFSET_SIGNED ? {{(WIDTH-12){shift_operand[11]}}, shift_operand}
                             : {{(WIDTH-12){1'b0}}, shift_operand};
    end else if (imm) begin
      w_data = {{(WIDTH-8){1'b0}}, shift_operand[7:0]};
      if (shift_operand[11:8] != 4'd0) begin
        w_kind = K_ROR;
        w_amt  = LOG'(int'({shift_operand[11:8], 1'b0}) % WIDTH);
      end
    end else if (w_amt8 == 8'd0) begin
      if (!shift_operand[4]) begin
        case (shift_operand[6:5])
          2'b01: begin w_data = '0;             w_c = w_msb;     end
          2'b10: begin w_data = {WIDTH{w_msb}}; w_c = w_msb;     end
          2'b11: begin w_data = {carry_in, val_rm[WIDTH-1:1]}; w_c = val_rm[0]; end
          default: ;
        endcase
      end
    end else begin
      case (shift_operand[6:5])
        2'b00: begin
          if (int'(w_amt8) < WIDTH) begin
            w_kind = K_LSL;
            w_amt  = LOG'(w_amt8);
          end else begin
            w_data = '0;
            w_c    = (int'(w_amt8) == WIDTH) ? val_rm[0] : 1'b0;
          end
        end
        2'b01: begin
          if (int'(w_amt8) < WIDTH) begin
            w_kind = K_LSR;
            w_amt  = LOG'(w_amt8);
          end else begin
            w_data = '0;
            w_c    = (int'(w_amt8) == WIDTH) ? w_msb : 1'b0;
          end
        end
        2'b10: begin
          if (int'(w_amt8) < WIDTH) begin
            w_kind = K_ASR;
            w_amt  = LOG'(w_amt8);
          end else begin
            w_data = {WIDTH{w_msb}};
            w_c    = w_msb;
          end
        end
        default: begin
          w_kind = K_ROR;
          w_amt  = LOG'(int'(w_amt8) % WIDTH);
        end
      endcase
    end
  end

  // Barrel: one extra bit on the shifted-out side captures the carry.
  always_comb begin
    w_ext  = '0;
    w_rot  = r_s1_data;
    w_res  = r_s1_data;
    w_cres = r_s1_c;
    case (r_s1_kind)
      K_LSL:        w_ext = {1'b0, r_s1_data};
      K_LSR, K_ASR: w_ext = {r_s1_data, 1'b0};
      default: ;
    endcase
    for (int k = 0; k < LOG; k++) begin
      if (r_s1_amt[k]) begin
        case (r_s1_kind)
          K_LSL:   w_ext = w_ext << (2**k);
          K_LSR:   w_ext = w_ext >> (2**k);
          K_ASR:   w_ext = $signed(w_ext) >>> (2**k);
          K_ROR:   w_rot = (w_rot >> (2**k)) | (w_rot << (WIDTH - 2**k));
          default: ;
        endcase
      end
    end
    case (r_s1_kind)
      K_LSL:        begin w_res = w_ext[WIDTH-1:0]; w_cres = w_ext[WIDTH];   end
      K_LSR, K_ASR: begin w_res = w_ext[WIDTH:1];   w_cres = w_ext[0];       end
      K_ROR:        begin w_res = w_rot;            w_cres = w_rot[WIDTH-1]; end
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_val2     <= '0;
      r_carry    <= 1'b0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_val2  <= w_res;
          r_carry <= w_cres;
        end
      end
      if (w_s1_adv) r_s1_valid <= in_valid;
    end
  end

  // NOTE: S1 payload is qualified by r_s1_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_s1_adv && in_valid) begin
      r_s1_kind <= w_kind;
      r_s1_amt  <= w_amt;
      r_s1_data <= w_data;
      r_s1_c    <= w_c;
    end
  end

  assign out_valid = r_s2_valid;
  assign val2      = r_val2;
  assign carry_out = r_carry;

endmodule

// File: tb/tb_shift_operand_pipe.sv
// Bench for shift_operand_pipe: directed corner cases, backpressure, flush and
// reset, then random traffic against an arithmetic reference model.
module tb_shift_operand_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, imm, mem_R_en, mem_W_en, carry_in, out_ready;
  logic [11:0] shift_operand;
  logic [31:0] val_rm;
  logic [7:0]  val_rs;
  logic        in_ready, out_valid, carry_out;
  logic [31:0] val2;
  logic        in_ready_s, out_valid_s, carry_s;
  logic [31:0] val2_s;

  typedef struct packed {
    logic [31:0] vu;
    logic [31:0] vs;
    logic        c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic last_acc;

  always #5 clk = ~clk;

  shift_operand_pipe #(.WIDTH(32), .OFFSET_SIGNED(1'b0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .mem_R_en(mem_R_en), .mem_W_en(mem_W_en), .shift_operand(shift_operand),
    .val_rm(val_rm), .val_rs(val_rs), .carry_in(carry_in), .out_valid(out_valid),
    .out_ready(out_ready), .val2(val2), .carry_out(carry_out));

  shift_operand_pipe #(.WIDTH(32), .OFFSET_SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
    .imm(imm), .mem_R_en(mem_R_en), .mem_W_en(mem_W_en), .shift_operand(shift_operand),
    .val_rm(val_rm), .val_rs(val_rs), .carry_in(carry_in), .out_valid(out_valid_s),
    .out_ready(out_ready), .val2(val2_s), .carry_out(carry_s));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {carry, val2}; shifts are done on 64-bit values so out-of-range
  // amounts fall out naturally.
  function automatic logic [32:0] ref_op(input logic i_imm, input logic i_mem,
                                         input logic [11:0] sh, input logic [31:0] rm,
                                         input logic [7:0] rs, input logic cin, input logic sgn);
    logic [63:0] t;
    logic [31:0] v;
    int          n;
    if (i_mem) begin
      v = sgn ? {{20{sh[11]}}, sh} : {20'b0, sh};
      return {cin, v};
    end
    if (i_imm) begin
      n = 2 * int'(sh[11:8]);
      t = {24'b0, sh[7:0], 24'b0, sh[7:0]} >> n;
      v = t[31:0];
      return {(n != 0) ? v[31] : cin, v};
    end
    n = sh[4] ? int'(rs) : int'(sh[11:7]);
    if (n == 0) begin
      if (sh[4] || sh[6:5] == 2'b00) return {cin, rm};
      if (sh[6:5] == 2'b11) return {rm[0], cin, rm[31:1]};
      n = 32;
    end
    case (sh[6:5])
      2'b00: begin t = {32'b0, rm} << n; return {t[32], t[31:0]}; end
      2'b01: begin t = {rm, 32'b0} >> n; return {t[31], t[63:32]}; end
      2'b10: begin t = $signed({rm, 32'b0}) >>> n; return {t[31], t[63:32]}; end
      default: begin
        t = {rm, rm} >> (n % 32);
        v = t[31:0];
        return {v[31], v};
      end
    endcase
  endfunction

  // One clock: scoreboard work at negedge, then return 1 time unit after posedge.
  task automatic step();
    exp_t        e;
    logic [32:0] ru, rs2;
    @(negedge clk);
    last_acc = 1'b0;
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("spurious_out", out_valid, 1'b0);
      else begin
        e = q.pop_front();
        check("val2", val2, e.vu);
        check("val2_signed", val2_s, e.vs);
        check("carry_out", carry_out, e.c);
        check("carry_out_signed", carry_s, e.c);
      end
    end
    if (rst || flush) q.delete();
    else if (in_valid && in_ready) begin
      ru   = ref_op(imm, mem_R_en | mem_W_en, shift_operand, val_rm, val_rs, carry_in, 1'b0);
      rs2  = ref_op(imm, mem_R_en | mem_W_en, shift_operand, val_rm, val_rs, carry_in, 1'b1);
      e.vu = ru[31:0];
      e.vs = rs2[31:0];
      e.c  = ru[32];
      q.push_back(e);
      last_acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic i_imm, input logic i_r, input logic i_w, input logic [11:0] sh,
                      input logic [31:0] rm, input logic [7:0] rs, input logic cin);
    imm = i_imm; mem_R_en = i_r; mem_W_en = i_w; shift_operand = sh;
    val_rm = rm; val_rs = rs; carry_in = cin; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_acc) break;
    end
    if (!last_acc) check("send_timeout", last_acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input logic i_imm, input logic i_w, input logic [11:0] sh,
                          input logic [31:0] rm, input logic [7:0] rs, input logic cin,
                          input logic [31:0] eu, input logic [31:0] es, input logic ec);
    out_ready = 1'b1;
    imm = i_imm; mem_R_en = 1'b0; mem_W_en = i_w; shift_operand = sh;
    val_rm = rm; val_rs = rs; carry_in = cin; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 1'b0);
    step();
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_val2"}, val2, eu);
    check({tag, "_val2_signed"}, val2_s, es);
    check({tag, "_carry"}, carry_out, ec);
    step();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; imm = 1'b0; mem_R_en = 1'b0; mem_W_en = 1'b0;
    carry_in = 1'b0; out_ready = 1'b1; shift_operand = '0; val_rm = '0; val_rs = '0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_val2", val2, 32'h0);
    check("rst_carry", carry_out, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);

    directed("rot_imm",  1'b1, 1'b0, 12'h4FF, 32'h0,        8'd0,  1'b0, 32'hFF000000, 32'hFF000000, 1'b1);
    directed("asr0",     1'b0, 1'b0, 12'h040, 32'h80000001, 8'd0,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    directed("lsr_rs32", 1'b0, 1'b0, 12'h030, 32'h80000000, 8'd32, 1'b0, 32'h0,        32'h0,        1'b1);
    directed("lsr_rs33", 1'b0, 1'b0, 12'h030, 32'h80000000, 8'd33, 1'b0, 32'h0,        32'h0,        1'b0);
    directed("offset",   1'b0, 1'b1, 12'hFFC, 32'h12345678, 8'd0,  1'b1, 32'h00000FFC, 32'hFFFFFFFC, 1'b1);
    directed("rrx",      1'b0, 1'b0, 12'h060, 32'h00000003, 8'd0,  1'b1, 32'h80000001, 32'h80000001, 1'b1);
    directed("lsl_rs32", 1'b0, 1'b0, 12'h010, 32'h00000001, 8'd32, 1'b0, 32'h0,        32'h0,        1'b1);
    directed("ror_rs64", 1'b0, 1'b0, 12'h070, 32'h80000001, 8'd64, 1'b0, 32'h80000001, 32'h80000001, 1'b1);
    directed("lsl5",     1'b0, 1'b0, 12'h280, 32'h08000001, 8'd0,  1'b0, 32'h00000020, 32'h00000020, 1'b1);

    // Backpressure: third op must stall while the first is held at the output.
    out_ready = 1'b0;
    send(1'b0, 1'b0, 1'b0, 12'h0A0, 32'hCAFEBABE, 8'd0, 1'b0);
    send(1'b0, 1'b0, 1'b0, 12'h150, 32'h12345678, 8'd7, 1'b1);
    check("bp_in_ready_full", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    imm = 1'b1; shift_operand = 12'h3AB; val_rm = 32'h0; carry_in = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_val2", val2, q[0].vu);
      check("bp_hold_carry", carry_out, q[0].c);
      check("bp_hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    send(1'b1, 1'b0, 1'b0, 12'h3AB, 32'h0, 8'd0, 1'b0);
    repeat (4) step();
    check("bp_drained", q.size(), 0);

    // Flush with two ops in flight plus one presented in the flush cycle.
    out_ready = 1'b0;
    send(1'b0, 1'b0, 1'b0, 12'h0C0, 32'h0F0F0F0F, 8'd0, 1'b1);
    send(1'b0, 1'b1, 1'b0, 12'h800, 32'h0,        8'd0, 1'b0);
    imm = 1'b0; shift_operand = 12'h020; val_rm = 32'hFFFF0000; in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (4) step();

    // Reset in the middle of a stream.
    send(1'b0, 1'b0, 1'b0, 12'h0E0, 32'h13579BDF, 8'd0, 1'b0);
    send(1'b0, 1'b0, 1'b0, 12'h050, 32'h80000000, 8'd4, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_val2", val2, 32'h0);
    check("midrst_carry", carry_out, 1'b0);
    repeat (4) step();

    // Random traffic, with Rs amounts biased towards the boundaries.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 9))
        0:       begin mem_R_en = 1'b1; mem_W_en = 1'b0; end
        1:       begin mem_R_en = 1'b0; mem_W_en = 1'b1; end
        default: begin mem_R_en = 1'b0; mem_W_en = 1'b0; end
      endcase
      imm           = ($urandom_range(0, 9) < 3);
      shift_operand = 12'($urandom);
      val_rm        = $urandom;
      carry_in      = 1'($urandom);
      case ($urandom_range(0, 6))
        0:       val_rs = 8'd0;
        1:       val_rs = 8'd31;
        2:       val_rs = 8'd32;
        3:       val_rs = 8'd33;
        4:       val_rs = 8'd64;
        default: val_rs = 8'($urandom);
      endcase
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (q.size() == 0 && !out_valid) break;
      step();
    end
    check("drain_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
